// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and duration table for the music box sequencer
package music_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam int DUR_CODE_W = 3;

    // Beat counts for each undotted duration code
    localparam int DUR_1  = 1;
    localparam int DUR_2  = 2;
    localparam int DUR_4  = 4;
    localparam int DUR_8  = 8;
    localparam int DUR_16 = 16;
    localparam int DUR_24 = 24;
    localparam int DUR_32 = 32;

endpackage

// File: rtl/dur_lut.sv
// rtl/dur_lut.sv - combinational duration code to beat count decode
module dur_lut
    import music_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic [DUR_CODE_W-1:0] dur_code,
    input  logic                  dot,
    output logic [CNT_W-1:0]      len
);

    logic [CNT_W-1:0] base;

    // Base length lookup; code 7 is a spare that plays as a single beat
    always_comb begin
        base = CNT_W'(DUR_1);
        case (dur_code)
            3'd0: base = CNT_W'(DUR_1);
            3'd1: base = CNT_W'(DUR_2);
            3'd2: base = CNT_W'(DUR_4);
            3'd3: base = CNT_W'(DUR_8);
            3'd4: base = CNT_W'(DUR_16);
            3'd5: base = CNT_W'(DUR_24);
            3'd6: base = CNT_W'(DUR_32);
            3'd7: base = CNT_W'(DUR_1);
        endcase
    end

    // Dotted notes add half the base, rounded down, so a dotted single beat stays 1
    assign len = dot ? (base + (base >> 1)) : base;

endmodule

// File: rtl/note_duration_sequencer.sv
// rtl/note_duration_sequencer.sv - holds a pitch for a decoded number of beats plus gap
module note_duration_sequencer
    import music_pkg::*;
#(
    parameter int PITCH_W   = 6,
    parameter int CNT_W     = 6,
    parameter int GAP_TICKS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_tick,
    input  logic                  enable,
    input  logic                  stop,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [DUR_CODE_W-1:0] dur_code,
    input  logic                  dot,
    input  logic [PITCH_W-1:0]    pitch_in,
    output logic [PITCH_W-1:0]    pitch_out,
    output logic                  tone_en,
    output logic                  note_done
);

    generate
        if (GAP_TICKS < 0 || GAP_TICKS >= (1 << CNT_W)) begin : g_bad_gap
            $error("GAP_TICKS must fit in CNT_W bits");
        end
        if ((1 << CNT_W) <= 48) begin : g_bad_cnt
            $error("CNT_W too narrow for a dotted 32-beat note");
        end
    endgenerate

    seq_state_t         state, state_nxt;
    logic [CNT_W-1:0]   remain, remain_nxt;
    logic [CNT_W-1:0]   gap, gap_nxt;
    logic [PITCH_W-1:0] pitch_nxt;
    logic               done_nxt;
    logic [CNT_W-1:0]   len;
    logic               tick_ok;

    dur_lut #(
        .CNT_W (CNT_W)
    ) u_dur_lut (
        .dur_code (dur_code),
        .dot      (dot),
        .len      (len)
    );

    // Ticks arriving while paused are dropped, not deferred
    assign tick_ok = beat_tick && enable;

    // Rests keep the gate closed; pausing mutes immediately
    assign tone_en = (state == PLAY) && (pitch_out != '0) && enable;

    // The done cycle is a mandatory bubble; stop blocks any accept
    assign note_ready = (state == IDLE) && !note_done && !stop;

    // Next-state, counter and output decode
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        gap_nxt    = gap;
        pitch_nxt  = pitch_out;
        done_nxt   = 1'b0;
        if (stop) begin
            state_nxt  = IDLE;
            remain_nxt = '0;
            gap_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (note_valid && note_ready) begin
                        remain_nxt = len;
                        pitch_nxt  = pitch_in;
                        state_nxt  = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_ok) begin
                        if (remain == CNT_W'(1)) begin
                            if (GAP_TICKS > 0) begin
                                state_nxt = GAP;
                                gap_nxt   = CNT_W'(GAP_TICKS);
                            end else begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            remain_nxt = remain - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick_ok) begin
                        if (gap == CNT_W'(1)) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            gap_nxt = gap - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remain    <= '0;
            gap       <= '0;
            pitch_out <= '0;
            note_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            remain    <= remain_nxt;
            gap       <= gap_nxt;
            pitch_out <= pitch_nxt;
            note_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_note_duration_sequencer.sv
// tb/tb_note_duration_sequencer.sv - directed checks for note_duration_sequencer
module tb_note_duration_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beat_tick = 1'b0;
    logic       enable = 1'b1;
    logic       stop = 1'b0;
    logic       note_valid = 1'b0;
    logic       note_valid0 = 1'b0;
    logic [2:0] dur_code = 3'd0;
    logic       dot = 1'b0;
    logic [5:0] pitch_in = 6'd0;

    logic       note_ready, tone_en, note_done;
    logic [5:0] pitch_out;
    logic       note_ready0, tone_en0, note_done0;
    logic [5:0] pitch_out0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    note_duration_sequencer #(.PITCH_W(6), .CNT_W(6), .GAP_TICKS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_tick  (beat_tick),
        .enable     (enable),
        .stop       (stop),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .dur_code   (dur_code),
        .dot        (dot),
        .pitch_in   (pitch_in),
        .pitch_out  (pitch_out),
        .tone_en    (tone_en),
        .note_done  (note_done)
    );

    note_duration_sequencer #(.PITCH_W(6), .CNT_W(6), .GAP_TICKS(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_tick  (beat_tick),
        .enable     (enable),
        .stop       (stop),
        .note_valid (note_valid0),
        .note_ready (note_ready0),
        .dur_code   (dur_code),
        .dot        (dot),
        .pitch_in   (pitch_in),
        .pitch_out  (pitch_out0),
        .tone_en    (tone_en0),
        .note_done  (note_done0)
    );

    task automatic chk(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        beat_tick = 1'b1;
        cyc();
        beat_tick = 1'b0;
        cyc();
    endtask

    task automatic accept(input logic [2:0] c, input logic d, input logic [5:0] p,
                          input logic tick_too);
        for (int w = 0; w < 20 && !note_ready; w++) cyc();
        chk("ready_before_accept", note_ready, 1);
        dur_code   = c;
        dot        = d;
        pitch_in   = p;
        note_valid = 1'b1;
        beat_tick  = tick_too;
        cyc();
        note_valid = 1'b0;
        beat_tick  = 1'b0;
    endtask

    task automatic count_to_done(output int tone_n, output int tick_n, output int done_n);
        tone_n = 0;
        tick_n = 0;
        done_n = 0;
        for (int k = 0; k < 100 && done_n == 0; k++) begin
            beat_tick = 1'b1;
            if (tone_en) tone_n++;
            tick_n++;
            cyc();
            beat_tick = 1'b0;
            if (note_done) done_n++;
            for (int j = 0; j < 2; j++) begin
                cyc();
                if (note_done) done_n++;
            end
        end
    endtask

    int exp_plain[8];
    int exp_dot[8];

    initial begin
        int tone_n, tick_n, done_n, dsum;
        exp_plain = '{1, 2, 4, 8, 16, 24, 32, 1};
        exp_dot   = '{1, 3, 6, 12, 24, 36, 48, 1};

        repeat (3) cyc();
        chk("rst_ready", note_ready, 1);
        chk("rst_pitch", pitch_out, 0);
        chk("rst_tone", tone_en, 0);
        chk("rst_done", note_done, 0);
        rst_n = 1'b1;
        cyc();

        // 1: code 3, pitch 12, tick during accept is ignored
        accept(3'd3, 1'b0, 6'd12, 1'b1);
        chk("t1_latency_tone", tone_en, 1);
        chk("t1_ready_in_play", note_ready, 0);
        chk("t1_pitch_play", pitch_out, 12);
        count_to_done(tone_n, tick_n, done_n);
        chk("t1_tone_ticks", tone_n, 8);
        chk("t1_total_ticks", tick_n, 9);
        chk("t1_done_count", done_n, 1);
        chk("t1_pitch_hold", pitch_out, 12);

        // 2: duration sweep
        for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < 2; d++) begin
                accept(3'(c), 1'(d), 6'd20, 1'b0);
                count_to_done(tone_n, tick_n, done_n);
                chk($sformatf("t2_len_c%0d_d%0d", c, d), tone_n,
                    (d != 0) ? exp_dot[c] : exp_plain[c]);
                chk($sformatf("t2_done_c%0d_d%0d", c, d), done_n, 1);
            end
        end

        // 3: rest
        accept(3'd1, 1'b0, 6'd0, 1'b0);
        count_to_done(tone_n, tick_n, done_n);
        chk("t3_rest_tone", tone_n, 0);
        chk("t3_rest_ticks", tick_n, 3);
        chk("t3_rest_done", done_n, 1);

        // 4: pause after 3 of 8 ticks
        accept(3'd3, 1'b0, 6'd5, 1'b0);
        repeat (3) pulse_tick();
        enable = 1'b0;
        #1;
        chk("t4_paused_tone", tone_en, 0);
        dsum = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            dsum += int'(note_done);
        end
        chk("t4_paused_tone_after", tone_en, 0);
        chk("t4_paused_ready", note_ready, 0);
        chk("t4_paused_done", dsum, 0);
        enable = 1'b1;
        #1;
        chk("t4_resume_tone", tone_en, 1);
        count_to_done(tone_n, tick_n, done_n);
        chk("t4_resume_tone_ticks", tone_n, 5);
        chk("t4_resume_total", tick_n, 6);

        // 5: stop at tick 4 of 16
        accept(3'd4, 1'b0, 6'd7, 1'b0);
        repeat (3) pulse_tick();
        beat_tick = 1'b1;
        stop      = 1'b1;
        cyc();
        beat_tick = 1'b0;
        chk("t5_stop_forces_notready", note_ready, 0);
        stop = 1'b0;
        #1;
        chk("t5_stop_tone", tone_en, 0);
        chk("t5_stop_ready", note_ready, 1);
        chk("t5_stop_done", note_done, 0);
        dsum = 0;
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            dsum += int'(note_done);
        end
        chk("t5_no_late_done", dsum, 0);

        // 6: back-to-back on the legato instance
        dur_code    = 3'd0;
        dot         = 1'b0;
        pitch_in    = 6'd9;
        note_valid0 = 1'b1;
        chk("t6_ready_idle", note_ready0, 1);
        cyc();
        chk("t6_tone_first", tone_en0, 1);
        chk("t6_ready_play", note_ready0, 0);
        beat_tick = 1'b1;
        cyc();
        beat_tick = 1'b0;
        chk("t6_done_pulse", note_done0, 1);
        chk("t6_bubble_ready", note_ready0, 0);
        chk("t6_bubble_tone", tone_en0, 0);
        cyc();
        chk("t6_done_cleared", note_done0, 0);
        chk("t6_ready_after_bubble", note_ready0, 1);
        pitch_in = 6'd33;
        cyc();
        note_valid0 = 1'b0;
        chk("t6_second_accept_tone", tone_en0, 1);
        chk("t6_second_pitch", pitch_out0, 33);
        chk("t6_second_ready", note_ready0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_tone", tone_en0, 0);
        chk("t6_async_pitch", pitch_out0, 0);
        chk("t6_async_ready", note_ready0, 1);
        chk("t6_async_done", note_done0, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_after_reset_done", note_done0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
